// File: rtl/memif_pkg.sv
// -----------------------------------------------------------------------------
// memif_pkg
// Shared definitions for the memory interface stage:
//   - state_e    : request/acknowledge FSM states
//   - SZ_*       : access-size encodings carried on the controller's lb bus
//   - calc_be    : byte-enable pattern for a size and byte offset
//   - calc_wdata : store-data lane replication for a size
//   - is_misaligned : word/halfword alignment test (used when the
//                     MEMIF_ALIGN_CHECK_EN build option is enabled)
// -----------------------------------------------------------------------------
package memif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] SZ_WORD   = 2'b00;
   localparam logic [1:0] SZ_BYTE_S = 2'b01;
   localparam logic [1:0] SZ_BYTE_U = 2'b10;
   localparam logic [1:0] SZ_HALF_S = 2'b11;

   function automatic logic [3:0] calc_be(input logic [1:0] size,
                                          input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_WORD:   be = 4'b1111;
         SZ_HALF_S: be = off[1] ? 4'b1100 : 4'b0011;
         default:   be = 4'b0001 << off;
      endcase
      return be;
   endfunction

   // The addressed lane is selected by m_be, so the store data is simply
   // replicated across every lane the size could land in.
   function automatic logic [31:0] calc_wdata(input logic [1:0]  size,
                                              input logic [31:0] wd);
      logic [31:0] wdata;
      case (size)
         SZ_WORD:   wdata = wd;
         SZ_HALF_S: wdata = {2{wd[15:0]}};
         default:   wdata = {4{wd[7:0]}};
      endcase
      return wdata;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
      logic mis;
      case (size)
         SZ_WORD:   mis = (off != 2'b00);
         SZ_HALF_S: mis = off[0];
         default:   mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/memif_ldext.sv
// -----------------------------------------------------------------------------
// memif_ldext
// Combinational load extractor: picks the addressed byte/halfword out of the
// memory read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata  in  32 : raw word from memory
//   size   in  2  : access size (SZ_* from memif_pkg)
//   off    in  2  : byte offset within the word (latched adr[1:0])
//   result out 32 : extended load value
// -----------------------------------------------------------------------------
module memif_ldext
   import memif_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      // halfword lane ignores off[0]; misaligned halfwords drop that bit
      half_sel = rdata[{off[1], 4'b0000} +: 16];
      case (size)
         SZ_WORD:   result = rdata;
         SZ_BYTE_S: result = {{24{byte_sel[7]}}, byte_sel};
         SZ_BYTE_U: result = {24'h00_0000, byte_sel};
         SZ_HALF_S: result = {{16{half_sel[15]}}, half_sel};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/memif.sv
// -----------------------------------------------------------------------------
// memif
// Memory interface stage between the multicycle controller and a
// variable-latency unified memory. Converts per-state memory strobes into a
// req/ack transaction, holds the IR and MDR, and stalls the controller until
// the access completes.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no access in flight; stall follows memread|memwrite
//   ST_WAIT | m_req high from latched copies; waiting for m_ack
//   ST_DONE | one cycle with stall low so the controller advances
//
// Ports:
//   clk_sys   in  1   : rising-edge clock
//   rst_b     in  1   : asynchronous active-low reset
//   adr       in  AW  : byte address from the IorD mux
//   wd        in  DW  : store data
//   memread   in  1   : controller reads memory (fetch or load)
//   memwrite  in  1   : controller writes memory
//   irwrite   in  1   : read data goes to IR (else MDR)
//   lb        in  2   : access size (SZ_* in memif_pkg)
//   instr     out DW  : instruction register
//   data      out DW  : memory data register, already extended
//   stall     out 1   : freeze controller state, pcen and regwrite
//   m_req     out 1   : memory request
//   m_we      out 1   : write request
//   m_adr     out AW  : word-aligned address
//   m_wdata   out DW  : lane-replicated store data
//   m_be      out 4   : byte enables
//   m_rdata   in  DW  : memory read data
//   m_ack     in  1   : access complete
//   misalign  out 1   : only with MEMIF_ALIGN_CHECK_EN; high during the DONE
//                       cycle of a rejected misaligned access
//
// Build option MEMIF_ALIGN_CHECK_EN: rejects misaligned word/halfword
// accesses without issuing them. Undefined: low address bits are dropped.
// -----------------------------------------------------------------------------
module memif
   import memif_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)
(
   input  logic          clk_sys,
   input  logic          rst_b,
   input  logic [AW-1:0] adr,
   input  logic [DW-1:0] wd,
   input  logic          memread,
   input  logic          memwrite,
   input  logic          irwrite,
   input  logic [1:0]    lb,
   output logic [DW-1:0] instr,
   output logic [DW-1:0] data,
   output logic          stall,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_adr,
   output logic [DW-1:0] m_wdata,
   output logic [3:0]    m_be,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack
`ifdef MEMIF_ALIGN_CHECK_EN
   ,
   output logic          misalign
`endif
);

   state_e        state_q,  state_d;
   logic [AW-1:0] adr_q,    adr_d;
   logic [DW-1:0] wd_q,     wd_d;
   logic [1:0]    lb_q,     lb_d;
   logic          irw_q,    irw_d;
   logic          we_q,     we_d;
   logic [DW-1:0] instr_q,  instr_d;
   logic [DW-1:0] data_q,   data_d;
`ifdef MEMIF_ALIGN_CHECK_EN
   logic          misalign_q, misalign_d;
`endif

   logic          access;
   logic          in_wait;
   logic [DW-1:0] ld_ext;

   assign access  = memread | memwrite;
   assign in_wait = (state_q == ST_WAIT);

   memif_ldext u_ldext (
      .rdata  (m_rdata),
      .size   (lb_q),
      .off    (adr_q[1:0]),
      .result (ld_ext)
   );

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      wd_d    = wd_q;
      lb_d    = lb_q;
      irw_d   = irw_q;
      we_d    = we_q;
      instr_d = instr_q;
      data_d  = data_q;
`ifdef MEMIF_ALIGN_CHECK_EN
      // single-cycle flag: only raised on the transition into DONE
      misalign_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               adr_d = adr;
               wd_d  = wd;
               lb_d  = lb;
               irw_d = irwrite;
               // write wins when both strobes are high
               we_d  = memwrite;
`ifdef MEMIF_ALIGN_CHECK_EN
               if (is_misaligned(lb, adr[1:0])) begin
                  misalign_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  state_d    = ST_WAIT;
               end
`else
               state_d = ST_WAIT;
`endif
            end
         end
         ST_WAIT: begin
            if (m_ack) begin
               if (!we_q) begin
                  if (irw_q) begin
                     instr_d = m_rdata;
                  end else begin
                     data_d  = ld_ext;
                  end
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         wd_q    <= '0;
         lb_q    <= SZ_WORD;
         irw_q   <= 1'b0;
         we_q    <= 1'b0;
         instr_q <= '0;
         data_q  <= '0;
`ifdef MEMIF_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         wd_q    <= wd_d;
         lb_q    <= lb_d;
         irw_q   <= irw_d;
         we_q    <= we_d;
         instr_q <= instr_d;
         data_q  <= data_d;
`ifdef MEMIF_ALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Memory-side outputs come only from state and latched copies, so no
   // controller input reaches the memory combinationally.
   assign m_req   = in_wait;
   assign m_we    = in_wait & we_q;
   assign m_be    = in_wait ? calc_be(lb_q, adr_q[1:0]) : 4'b0000;
   assign m_adr   = {adr_q[AW-1:2], 2'b00};
   assign m_wdata = calc_wdata(lb_q, wd_q);

   // IDLE stall is combinational so the controller freezes in cycle N itself.
   assign stall   = ((state_q == ST_IDLE) & access) | in_wait;

   assign instr   = instr_q;
   assign data    = data_q;
`ifdef MEMIF_ALIGN_CHECK_EN
   assign misalign = misalign_q;
`endif

endmodule
